// File: rtl/fp_wb_arbiter.sv
// FP register-file write-back arbiter: round-robin grant over NREQ units,
// registered write port, per-register busy scoreboard and fflags accumulator.
module fp_wb_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*5-1:0] req_rd,
    input  logic [NREQ*32-1:0] req_data,
    input  logic [NREQ*5-1:0] req_flags,
    output logic [NREQ-1:0]   req_ready,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    input  logic              flush,
    output logic              rf_we,
    output logic [4:0]        rf_wa,
    output logic [31:0]       rf_wd,
    output logic [31:0]       busy,
    output logic [4:0]        fflags_acc,
    input  logic              fflags_clr
);

    localparam int LW = $clog2(NREQ);

    logic [LW-1:0] last_grant;
    logic [LW-1:0] gidx;
    logic [LW-1:0] cand;
    logic          xfer;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;
    logic [4:0]    sel_flags;
    logic [31:0]   busy_nxt;

    // Search starts just after the last winner; grant depends only on valids.
    always_comb begin
        req_ready = '0;
        gidx      = '0;
        cand      = '0;
        xfer      = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = LW'((int'(last_grant) + k) % NREQ);
            if (!xfer && req_valid[cand]) begin
                xfer            = 1'b1;
                req_ready[cand] = 1'b1;
                gidx            = cand;
            end
        end
    end

    always_comb begin
        sel_rd    = '0;
        sel_data  = '0;
        sel_flags = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_rd    = req_rd[i*5 +: 5];
                sel_data  = req_data[i*32 +: 32];
                sel_flags = req_flags[i*5 +: 5];
            end
        end
    end

    // Issue set overrides flush, which overrides write-back clear.
    always_comb begin
        busy_nxt = busy;
        if (rf_we) busy_nxt[rf_wa] = 1'b0;
        if (flush) busy_nxt = '0;
        if (issue_valid) busy_nxt[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_wa      <= '0;
            rf_wd      <= '0;
            busy       <= '0;
            fflags_acc <= '0;
            last_grant <= LW'(NREQ - 1);
        end else begin
            rf_we <= xfer;
            busy  <= busy_nxt;
            if (xfer) begin
                last_grant <= gidx;
                rf_wa      <= sel_rd;
                rf_wd      <= sel_data;
                fflags_acc <= (fflags_clr ? 5'b0 : fflags_acc) | sel_flags;
            end else if (fflags_clr) begin
                fflags_acc <= '0;
            end
        end
    end

endmodule
